qdec_ctu_syntax_reader: RTL and testbench
=========================================

# qdec_ctu_syntax_reader

Drains the decoded-CTU syntax line buffer written by `qdec_cabac`. On each CTU-done pulse it reads the CTU's bytes through the `lb_raddr`/`lb_re`/`lb_dout` port, which has 1-cycle read latency. It re-times them into a backpressured valid/ready byte stream for downstream reconstruction stages. It is the reader end of the CABAC line-buffer interface and sits between `qdec_cabac` and the inverse-transform/prediction front end.

## Interface
- `ADDR_WIDTH`, 12, line-buffer address width.
- `DATA_WIDTH`, 8, line-buffer and stream byte width.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `ctu_done`  in  1  one-cycle pulse from `qdec_cabac` (`ctu_done_intr`): the CTU syntax is complete in the line buffer.
- `ctu_len`  in  ADDR_WIDTH+1  byte count of the CTU; sampled only with `ctu_done`.
- `lb_raddr`  out  ADDR_WIDTH  line-buffer read address.
- `lb_re`  out  1  line-buffer read enable.
- `lb_dout`  in  DATA_WIDTH  read data, valid the cycle after `lb_re`.
- `syn_dout`  out  DATA_WIDTH  stream data.
- `syn_vld`  out  1  stream valid.
- `syn_rdy`  in  1  stream ready.
- `syn_last`  out  1  marks the final byte of the CTU; qualified by `syn_vld`.
- `busy`  out  1  high whenever the state is not IDLE.
- `ctu_ack`  out  1  one-cycle pulse when the CTU has been fully consumed.
- `overflow_err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `overflow_err`.

## Operation
- **States:** IDLE, READ, DRAIN.
- **IDLE:**
  - `ctu_done` with `ctu_len`>0 latches `len`, clears `rd_cnt` to 0 and goes to READ.
  - `ctu_done` with `ctu_len`==0 pulses `ctu_ack` in the next cycle and stays in IDLE.
- **READ:**
  - `lb_re` = `rd_cnt`<`len` && (`occ` + `inflight` − `pop`) < 2. This is combinational.
  - `lb_raddr` = `rd_cnt`, and `rd_cnt` increments on each `lb_re`.
  - The state goes to DRAIN on the edge where the read of address `len`−1 is issued.
- **DRAIN:**
  - The state waits for the handshake of the byte with `syn_last`.
  - It then pulses `ctu_ack` in the next cycle and returns to IDLE.
- **Output buffer:**
  - 2-entry FIFO; `occ` ∈ {0,1,2}.
  - `inflight` is a 1-bit register = `lb_re` of the previous cycle.
  - `lb_dout` is written into the FIFO when `inflight`=1.
  - `pop` = `syn_vld` && `syn_rdy`.
  - The credit rule guarantees no write while full; this is an assertion in the bench.
- **`syn_last`:** tagged on the FIFO entry whose source address was `len`−1, via a 1-bit flag carried alongside `inflight`.
- **`syn_dout`, `syn_vld`, `syn_last`** are driven from the FIFO head.
- **`ctu_done` while `busy`:** the pulse is ignored and `overflow_err` is set. The current CTU completes normally.
- **Error flag:**
  - `err_clr` clears `overflow_err`.
  - If a set and `err_clr` occur in the same cycle, set wins.
- **Widths:** `rd_cnt` and `len` are ADDR_WIDTH+1 bits, so `len` = 4096 is legal. `lb_raddr` = `rd_cnt`[ADDR_WIDTH-1:0], with no wrap.

## Timing
- **Reset values:** all outputs are 0 (`lb_raddr`, `lb_re`, `syn_dout`, `syn_vld`, `syn_last`, `busy`, `ctu_ack`, `overflow_err`). The FIFO is empty, `inflight`=0 and the state is IDLE.
- **Reset mid-operation** aborts immediately. There is no `ctu_ack` for the aborted CTU.
- **Latency with `ctu_done` in cycle T:**
  - `busy` is high from T+1.
  - The first `lb_re` (addr 0) is in T+1, and `lb_dout` is valid in T+2.
  - The first `syn_vld` is in T+3.
- **Throughput:** with `syn_rdy` held high, one byte per cycle.
  - The last byte is presented in T+2+N.
  - `ctu_ack` is in T+3+N.
  - `busy` falls in T+3+N (the IDLE state is entered at the end of T+3+N−1 handshake edge + 1). Precisely, `busy` and `ctu_ack` are high in T+3+N and `busy` is low in T+4+N.
- **Stream rules:**
  - Once `syn_vld` is high, `syn_dout` and `syn_last` are held stable until the handshake.
  - `syn_vld` never drops without a handshake.
- **Backpressure:** with `syn_rdy` low, at most 2 bytes are buffered and `lb_re` stays low. Reads resume in the cycle `syn_rdy` rises, because `pop` is included in the credit.
- **`ctu_done` in the cycle `busy` falls** (state is IDLE) is accepted, not an error.

## Test plan
- **Single CTU, no backpressure:** `ctu_len`=16, line buffer holds bytes 0x10..0x1F, `syn_rdy`=1. Required response:
  - `lb_re` for 16 consecutive cycles starting at T+1.
  - Stream of 0x10..0x1F in T+3..T+18, with `syn_last` only on 0x1F.
  - `ctu_ack` at T+19.
- **Backpressure:** `ctu_len`=8 with `syn_rdy` toggling 1,0,0,1… and random stalls. Required response:
  - The byte order is preserved with no loss or duplication.
  - `lb_re` never issues when `occ`+`inflight`−`pop` ≥ 2.
  - The FIFO never overflows.
  - `syn_dout` is stable during stalls.
- **Zero length:** `ctu_len`=0. Required response: no `lb_re`, no `syn_vld`, `ctu_ack` at T+1, `busy` stays 0.
- **Overflow:** a second `ctu_done` at T+5 during a `ctu_len`=32 CTU. Required response:
  - `overflow_err`=1 from T+6.
  - All 32 bytes are still delivered, with a single `ctu_ack`.
  - `err_clr` then returns `overflow_err` to 0.
- **Max length and back-to-back:** `ctu_len`=4096 (addresses 0..0xFFF), followed by a second CTU whose `ctu_done` is in the first IDLE cycle. Required response:
  - `lb_raddr` reaches 0xFFF, and `syn_last` falls on the 4096th byte.
  - The second CTU is accepted with no error.
- **Reset mid-CTU:** assert `rst_n`=0 after 5 bytes of a `ctu_len`=20 CTU. Required response:
  - All outputs are 0 immediately.
  - After release a new `ctu_len`=4 CTU streams correctly from addr 0.

Source files
------------

// File: rtl/qdec_ctu_syntax_reader.sv
// qdec_ctu_syntax_reader
// Reads one decoded CTU out of the CABAC syntax line buffer after each
// ctu_done pulse. The line buffer has a 1-cycle read latency. The bytes are
// re-timed into a valid/ready stream through a 2-entry output buffer.
// Reads are credit-limited, so a returning byte always has a free slot.
module qdec_ctu_syntax_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctu_done,
    input  logic [ADDR_WIDTH:0]   ctu_len,
    output logic [ADDR_WIDTH-1:0] lb_raddr,
    output logic                  lb_re,
    input  logic [DATA_WIDTH-1:0] lb_dout,
    output logic [DATA_WIDTH-1:0] syn_dout,
    output logic                  syn_vld,
    input  logic                  syn_rdy,
    output logic                  syn_last,
    output logic                  busy,
    output logic                  ctu_ack,
    output logic                  overflow_err,
    input  logic                  err_clr
);

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DRAIN} ctuState_t;

    ctuState_t             state;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   rdCnt;
    logic [ADDR_WIDTH:0]   lenMinus1;
    logic                  inflight;
    logic                  inflightLast;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] headData;
    logic [DATA_WIDTH-1:0] tailData;
    logic                  headLast;
    logic                  tailLast;
    logic                  pop;
    logic                  isLastAddr;
    logic [2:0]            credit;

    assign pop        = syn_vld && syn_rdy;
    assign lenMinus1  = len - ONE;
    assign isLastAddr = (rdCnt == lenMinus1);
    // Projected buffer occupancy one cycle ahead. Counting this cycle's pop
    // lets reads resume in the same cycle that syn_rdy rises.
    assign credit     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign lb_re      = (state == READ) && (rdCnt < len) && (credit < 3'd2);
    assign lb_raddr   = rdCnt[ADDR_WIDTH-1:0];
    assign busy       = (state != IDLE);
    assign syn_vld    = (occ != 2'd0);
    assign syn_dout   = headData;
    assign syn_last   = headLast;

    // CTU sequencing: accept, issue reads, wait for the last byte, then acknowledge.
    // In DRAIN with ctu_ack high, the state stays DRAIN for the ack cycle, so busy
    // and ctu_ack overlap for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len     <= '0;
            rdCnt   <= '0;
            ctu_ack <= 1'b0;
        end else begin
            ctu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctu_done) begin
                        if (ctu_len != '0) begin
                            len   <= ctu_len;
                            rdCnt <= '0;
                            state <= READ;
                        end else begin
                            ctu_ack <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (lb_re) begin
                        rdCnt <= rdCnt + ONE;
                        if (isLastAddr) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ctu_ack)               state   <= IDLE;
                    else if (pop && syn_last)  ctu_ack <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track reads in flight through the line-buffer latency, with the last-byte tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
        end else begin
            inflight     <= lb_re;
            inflightLast <= lb_re && isLastAddr;
        end
    end

    // Two-entry output buffer. The head register drives the stream directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            headData <= '0;
            headLast <= 1'b0;
            tailData <= '0;
            tailLast <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        headData <= lb_dout;
                        headLast <= inflightLast;
                    end else begin
                        tailData <= lb_dout;
                        tailLast <= inflightLast;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    headData <= tailData;
                    headLast <= tailLast;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        headData <= lb_dout;
                        headLast <= inflightLast;
                    end else begin
                        headData <= tailData;
                        headLast <= tailLast;
                        tailData <= lb_dout;
                        tailLast <= inflightLast;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow flag. When a new overflow and err_clr arrive together,
    // the overflow wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    overflow_err <= 1'b0;
        else if (ctu_done && busy)     overflow_err <= 1'b1;
        else if (err_clr)              overflow_err <= 1'b0;
    end

endmodule

// File: tb/tb_qdec_ctu_syntax_reader.sv
// Directed bench for qdec_ctu_syntax_reader: a table of CTU scenarios run
// through a cycle-accurate stream scoreboard, plus hand sequences for error
// clear and reset mid-CTU.
module tb_qdec_ctu_syntax_reader;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctu_done = 1'b0;
    logic [AW:0]   ctu_len = '0;
    logic [AW-1:0] lb_raddr;
    logic          lb_re;
    logic [DW-1:0] lb_dout = '0;
    logic [DW-1:0] syn_dout;
    logic          syn_vld;
    logic          syn_rdy = 1'b0;
    logic          syn_last;
    logic          busy;
    logic          ctu_ack;
    logic          overflow_err;
    logic          err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    qdec_ctu_syntax_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ctu_done(ctu_done), .ctu_len(ctu_len),
        .lb_raddr(lb_raddr), .lb_re(lb_re), .lb_dout(lb_dout),
        .syn_dout(syn_dout), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
        .syn_last(syn_last), .busy(busy), .ctu_ack(ctu_ack),
        .overflow_err(overflow_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lbByte(input int a);
        return 8'(a + 16);
    endfunction

    // Line-buffer model with 1-cycle read latency.
    always @(posedge clk) if (lb_re) lb_dout <= lbByte(int'(lb_raddr));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_raddr"}, int'(lb_raddr), 0);
        chk({tag, "_re"}, int'(lb_re), 0);
        chk({tag, "_dout"}, int'(syn_dout), 0);
        chk({tag, "_vld"}, int'(syn_vld), 0);
        chk({tag, "_last"}, int'(syn_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ack"}, int'(ctu_ack), 0);
        chk({tag, "_err"}, int'(overflow_err), 0);
    endtask

    // Entered just after a falling edge; cycle 0 carries ctu_done.
    // Returns just after the falling edge of the cycle following ctu_ack.
    task automatic runCtu(input int len, input int mode, input bit inject, input int expAck);
        int rdIdx = 0, rxIdx = 0, occM = 0, ackCnt = 0, ackAt = -1;
        int firstRe = -1, firstVld = -1, limit = len * 8 + 40;
        bit prevRe = 0, prevVld = 0, prevPop = 0, popNow, inflNow;
        logic [7:0] prevDout = '0;
        logic prevLast = 1'b0;
        for (int c = 0; c < limit; c++) begin
            ctu_done = (c == 0) || (inject && c == 5);
            ctu_len  = (c == 0) ? len[AW:0] : 13'd7;
            case (mode)
                0: syn_rdy = 1'b1;
                1: syn_rdy = ((c % 3) == 0);
                default: syn_rdy = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (c == 0) begin
                chk("start_busy", int'(busy), 0);
                chk("start_err", int'(overflow_err), 0);
            end
            popNow  = syn_vld && syn_rdy;
            inflNow = prevRe;
            chk("vld_vs_occ", int'(syn_vld), int'(occM != 0));
            if (prevVld && !prevPop) begin
                chk("stall_vld", int'(syn_vld), 1);
                chk("stall_dout", int'(syn_dout), int'(prevDout));
                chk("stall_last", int'(syn_last), int'(prevLast));
            end
            if (lb_re) begin
                chk("raddr", int'(lb_raddr), rdIdx);
                chk("credit", int'((occM + int'(inflNow) - int'(popNow)) < 2), 1);
                if (firstRe < 0) firstRe = c;
                rdIdx++;
            end
            if (popNow) begin
                chk("dout", int'(syn_dout), int'(lbByte(rxIdx)));
                chk("last", int'(syn_last), int'(rxIdx == len - 1));
                rxIdx++;
            end
            if (syn_vld && firstVld < 0) firstVld = c;
            if (inject && c == 6) chk("ovf_set", int'(overflow_err), 1);
            if (ctu_ack) begin
                ackCnt++;
                ackAt = c;
                chk("ack_busy", int'(busy), int'(len > 0));
            end
            occM     = occM + int'(inflNow) - int'(popNow);
            prevRe   = lb_re;
            prevVld  = syn_vld;
            prevPop  = popNow;
            prevDout = syn_dout;
            prevLast = syn_last;
            if (ctu_ack) break;
            @(negedge clk);
        end
        ctu_done = 1'b0;
        chk("ack_seen", ackCnt, 1);
        chk("bytes_rx", rxIdx, len);
        chk("reads", rdIdx, len);
        if (expAck >= 0) chk("ack_cycle", ackAt, expAck);
        if (len > 0) begin
            chk("first_re", firstRe, 1);
            chk("first_vld", firstVld, 3);
        end
        @(negedge clk);
        #1;
        chk("busy_after", int'(busy), 0);
        chk("ack_single", int'(ctu_ack), 0);
        if (!inject) chk("no_err", int'(overflow_err), 0);
    endtask

    typedef struct {
        int len;
        int mode;
        bit inject;
        bit chain;
        int expAck;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pops;
        bit sawFive;
        vecs[0] = '{16,   0, 1'b0, 1'b0, 19};
        vecs[1] = '{8,    1, 1'b0, 1'b0, -1};
        vecs[2] = '{8,    2, 1'b0, 1'b0, -1};
        vecs[3] = '{0,    0, 1'b0, 1'b0, 1};
        vecs[4] = '{32,   0, 1'b1, 1'b0, 35};
        vecs[5] = '{1,    0, 1'b0, 1'b0, 4};
        vecs[6] = '{4096, 0, 1'b0, 1'b0, 4099};
        vecs[7] = '{5,    0, 1'b0, 1'b1, 8};

        #2;
        chkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].chain) repeat (2) @(negedge clk);
            runCtu(vecs[i].len, vecs[i].mode, vecs[i].inject, vecs[i].expAck);
            if (vecs[i].inject) begin
                chk("ovf_hold", int'(overflow_err), 1);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                #1;
                chk("ovf_clr", int'(overflow_err), 0);
            end
        end

        // Reset in the middle of a 20-byte CTU, once 5 bytes have been accepted.
        repeat (2) @(negedge clk);
        pops = 0;
        sawFive = 1'b0;
        ctu_done = 1'b1;
        ctu_len = 13'd20;
        syn_rdy = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (syn_vld && syn_rdy) pops++;
            if (pops == 5) begin
                sawFive = 1'b1;
                break;
            end
            @(negedge clk);
            ctu_done = 1'b0;
        end
        ctu_done = 1'b0;
        chk("mid_five_bytes", int'(sawFive), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkAllZero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runCtu(4, 0, 1'b0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
